// File: rtl/det_job_sequencer_if.sv
// Signal bundle between det_job_sequencer, the host loader, the determinant engine and the SRAM.
// The wdog_err member exists only when DET_SEQ_WATCHDOG_EN is defined.
interface det_job_sequencer_if #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 32,
  parameter int MAX_JOBS = 8
);
  logic                host_start;
  logic [3:0]          host_jobs;
  logic                host_req;
  logic                host_we;
  logic [ADDR_W-1:0]   host_addr;
  logic [DATA_W-1:0]   host_wdata;
  logic                host_gnt;
  logic [DATA_W-1:0]   host_rdata;
  logic                busy;
  logic                done;
  logic [3:0]          jobs_done;
  logic [MAX_JOBS-1:0] ovf_mask;
  logic                det_go;
  logic                det_finished;
  logic                det_overflow;
  logic [ADDR_W-1:0]   det_raddr;
  logic [ADDR_W-1:0]   det_waddr;
  logic                det_we;
  logic [DATA_W-1:0]   det_wdata;
  logic [DATA_W-1:0]   det_rdata;
  logic [ADDR_W-1:0]   sram_addr;
  logic                sram_we;
  logic [DATA_W-1:0]   sram_wdata;
  logic [DATA_W-1:0]   sram_rdata;
`ifdef DET_SEQ_WATCHDOG_EN
  logic                wdog_err;
`endif

  // Handshakes: the host owns the SRAM port in exactly the cycles host_gnt is 1 (no queuing, a
  // refused request is simply not performed); det_go is a one-cycle start pulse and the engine
  // reports completion with a 0->1 edge on det_finished, det_overflow being valid on that edge.
  modport slave (
    input  host_start, host_jobs, host_req, host_we, host_addr, host_wdata,
    input  det_finished, det_overflow, det_raddr, det_waddr, det_we, det_wdata,
    input  sram_rdata,
    output host_gnt, host_rdata, busy, done, jobs_done, ovf_mask,
    output det_go, det_rdata, sram_addr, sram_we, sram_wdata
`ifdef DET_SEQ_WATCHDOG_EN
    , output wdog_err
`endif
  );

  modport master (
    output host_start, host_jobs, host_req, host_we, host_addr, host_wdata,
    output det_finished, det_overflow, det_raddr, det_waddr, det_we, det_wdata,
    output sram_rdata,
    input  host_gnt, host_rdata, busy, done, jobs_done, ovf_mask,
    input  det_go, det_rdata, sram_addr, sram_we, sram_wdata
`ifdef DET_SEQ_WATCHDOG_EN
    , input wdog_err
`endif
  );
endinterface

// File: rtl/det_job_sequencer.sv
// Batch sequencer for the determinant engine: runs one job per 16-word SRAM slot and arbitrates
// the SRAM port between host and engine. DET_SEQ_WATCHDOG_EN adds a per-job run-cycle watchdog.
module det_job_sequencer #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 32,
  parameter int SLOT_W   = 4,
  parameter int MAX_JOBS = 8
`ifdef DET_SEQ_WATCHDOG_EN
  , parameter int WDOG_CYC = 255
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  det_job_sequencer_if.slave   io_bus,
  output logic [2:0]           o_state
);
  localparam int SLOTN_W = ADDR_W - SLOT_W;
  localparam logic [SLOTN_W-1:0] SLOT_ONE = SLOTN_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_NEXT, S_FIN} state_t;

  state_t              r_state, w_next;
  logic [SLOTN_W-1:0]  r_slot;
  logic [3:0]          r_count;
  logic [3:0]          r_jobs_done;
  logic [MAX_JOBS-1:0] r_ovf_mask;
  logic                r_fin_q;
  logic                r_ovf_cap;
  logic [3:0]          w_jobs_clamped;
  logic                w_fin_rise;
  logic                w_last;
  logic                w_busy;
  logic                w_start;
  logic                w_timeout;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_unused_addr_hi;

  assign w_jobs_clamped = (io_bus.host_jobs > 4'(MAX_JOBS)) ? 4'(MAX_JOBS) : io_bus.host_jobs;
  // Only a fresh 0->1 transition ends a job; a level held over from the previous job is ignored.
  assign w_fin_rise     = io_bus.det_finished & ~r_fin_q;
  assign w_last         = (4'(r_slot) == (r_count - 4'd1));
  assign w_busy         = (r_state != S_IDLE);
  assign w_start        = (r_state == S_IDLE) && io_bus.host_start;
  assign w_rdata        = io_bus.sram_rdata;
  assign w_unused_addr_hi = ^{io_bus.det_raddr[ADDR_W-1:SLOT_W], io_bus.det_waddr[ADDR_W-1:SLOT_W]};

`ifdef DET_SEQ_WATCHDOG_EN
  logic [7:0] r_wdog_cnt;
  logic       r_wdog_err;

  assign w_timeout       = (r_state == S_RUN) && (r_wdog_cnt == 8'(WDOG_CYC));
  assign io_bus.wdog_err = r_wdog_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      if (r_state == S_LAUNCH)   r_wdog_cnt <= '0;
      else if (r_state == S_RUN) r_wdog_cnt <= r_wdog_cnt + 8'd1;
      if (w_start)        r_wdog_err <= 1'b0;
      else if (w_timeout) r_wdog_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (io_bus.host_start) w_next = (w_jobs_clamped != 4'd0) ? S_LAUNCH : S_FIN;
      S_LAUNCH: w_next = S_RUN;
      S_RUN:    if (w_fin_rise || w_timeout) w_next = S_NEXT;
      S_NEXT:   w_next = w_last ? S_FIN : S_LAUNCH;
      S_FIN:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot      <= '0;
      r_count     <= '0;
      r_jobs_done <= '0;
      r_ovf_mask  <= '0;
      r_fin_q     <= 1'b0;
      r_ovf_cap   <= 1'b0;
    end else begin
      r_fin_q <= io_bus.det_finished;
      if (w_start) begin
        r_count <= w_jobs_clamped;
        // An empty batch leaves the previous results visible.
        if (w_jobs_clamped != 4'd0) begin
          r_slot      <= '0;
          r_jobs_done <= '0;
          r_ovf_mask  <= '0;
        end
      end
      if ((r_state == S_RUN) && (w_fin_rise || w_timeout))
        r_ovf_cap <= (w_fin_rise & io_bus.det_overflow) | w_timeout;
      if (r_state == S_NEXT) begin
        r_ovf_mask[r_slot] <= r_ovf_cap;
        r_jobs_done        <= r_jobs_done + 4'd1;
        if (!w_last) r_slot <= r_slot + SLOT_ONE;
      end
    end
  end

  assign io_bus.busy      = w_busy;
  assign io_bus.done      = (r_state == S_FIN);
  assign io_bus.det_go    = (r_state == S_LAUNCH);
  assign io_bus.jobs_done = r_jobs_done;
  assign io_bus.ovf_mask  = r_ovf_mask;
  assign io_bus.host_rdata = w_rdata;
  assign io_bus.det_rdata  = w_rdata;
  assign o_state          = r_state;

  // Engine addresses keep only their in-slot offset, so a job can never reach another slot.
  always_comb begin
    io_bus.host_gnt   = 1'b0;
    io_bus.sram_addr  = io_bus.host_addr;
    io_bus.sram_we    = io_bus.host_we & io_bus.host_req;
    io_bus.sram_wdata = io_bus.host_wdata;
    if (w_busy) begin
      io_bus.sram_addr  = {r_slot, io_bus.det_we ? io_bus.det_waddr[SLOT_W-1:0]
                                                 : io_bus.det_raddr[SLOT_W-1:0]};
      io_bus.sram_we    = io_bus.det_we;
      io_bus.sram_wdata = io_bus.det_wdata;
    end else begin
      io_bus.host_gnt   = io_bus.host_req;
    end
  end
endmodule

// File: tb/tb_det_job_sequencer.sv
// Self-checking bench for det_job_sequencer: batch-level reference model, engine responder,
// per-cycle output comparison and directed literal checks.
module tb_det_job_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  det_job_sequencer_if #(.ADDR_W(7), .DATA_W(32), .MAX_JOBS(8)) bus_if ();

  det_job_sequencer dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus_if),
    .o_state (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- engine responder ----------------
  int         eng_lat  = 40;
  bit         eng_hold = 1'b0;
  bit         eng_fix  = 1'b0;
  logic [7:0] ovf_pat  = 8'b1010_0110;
  int         go_total = 0;
  int         go_base  = 0;
  int         eng_cnt  = -1;
  int         eng_drop = -1;

  always @(posedge clk) begin
    #1;
    bus_if.sram_rdata <= $urandom;
    bus_if.det_raddr  <= 7'($urandom_range(0, 127));
    bus_if.det_wdata  <= $urandom;
    bus_if.det_we     <= eng_fix ? 1'b1 : 1'($urandom_range(0, 1));
    bus_if.det_waddr  <= eng_fix ? 7'h7E : 7'($urandom_range(0, 127));
    if (!rst_n) begin
      bus_if.det_finished = 1'b0;
      bus_if.det_overflow = 1'b0;
      eng_cnt  = -1;
      eng_drop = -1;
    end else begin
      if (bus_if.det_finished && !eng_hold) bus_if.det_finished = 1'b0;
      if (eng_drop > 0) begin
        eng_drop--;
        if (eng_drop == 0) begin
          bus_if.det_finished = 1'b0;
          eng_drop = -1;
        end
      end
      if (bus_if.det_go) begin
        eng_cnt = eng_lat;
        if (bus_if.det_finished) eng_drop = 2;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          bus_if.det_finished = 1'b1;
          bus_if.det_overflow = ovf_pat[(go_total - go_base - 1) & 7];
          eng_cnt = -1;
        end
      end
    end
  end

  // ---------------- reference model (batch schedule) ----------------
  int         m_cyc = 0;
  bit         m_active = 1'b0;
  int         m_n = 0;
  int         m_jd = 0;
  logic [7:0] m_ovf = 8'h00;
  int         m_go_at = -1;
  int         m_done_at = -1;
  int         m_wait_from = -1;
  int         m_upd_at = -1;
  int         m_upd_jd = 0;
  logic [7:0] m_upd_ovf = 8'h00;
  logic       m_prev_fin = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_jd = 0; m_ovf = 8'h00; m_go_at = -1; m_done_at = -1;
      m_wait_from = -1; m_upd_at = -1; m_prev_fin = 1'b0;
    end else begin
      m_cyc++;
      if (!m_active && bus_if.host_start) begin
        m_n = (int'(bus_if.host_jobs) > 8) ? 8 : int'(bus_if.host_jobs);
        m_active = 1'b1;
        if (m_n == 0) m_done_at = m_cyc;
        else begin
          m_go_at = m_cyc; m_wait_from = m_cyc + 1; m_jd = 0; m_ovf = 8'h00;
        end
      end else if (m_active && m_done_at == m_cyc - 1) begin
        m_active = 1'b0;
      end else if (m_active && m_wait_from >= 0 && (m_cyc - 1) >= m_wait_from &&
                   bus_if.det_finished && !m_prev_fin) begin
        m_upd_at = m_cyc + 1;
        m_upd_jd = m_jd + 1;
        m_upd_ovf = m_ovf;
        m_upd_ovf[m_jd] = bus_if.det_overflow;
        m_wait_from = -1;
        if (m_jd + 1 == m_n) m_done_at = m_cyc + 1;
        else begin
          m_go_at = m_cyc + 1; m_wait_from = m_cyc + 2;
        end
      end
      if (m_cyc == m_upd_at) begin
        m_jd = m_upd_jd; m_ovf = m_upd_ovf;
      end
      m_prev_fin = bus_if.det_finished;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit         e_busy, e_done, e_go;
    int         e_slot;
    logic [6:0] e_addr;
    e_busy = m_active;
    e_done = m_active && (m_cyc == m_done_at);
    e_go   = m_active && (m_cyc == m_go_at);
    check("busy", bus_if.busy, e_busy);
    check("done", bus_if.done, e_done);
    check("det_go", bus_if.det_go, e_go);
    check("jobs_done", bus_if.jobs_done, m_jd);
    check("ovf_mask", bus_if.ovf_mask, m_ovf);
    check("host_rdata", bus_if.host_rdata, bus_if.sram_rdata);
    check("det_rdata", bus_if.det_rdata, bus_if.sram_rdata);
    if (e_busy) begin
      check("host_gnt_busy", bus_if.host_gnt, 0);
      check("sram_we_eng", bus_if.sram_we, bus_if.det_we);
      check("sram_wdata_eng", bus_if.sram_wdata, bus_if.det_wdata);
      if (m_n > 0) begin
        e_slot = (m_jd < m_n) ? m_jd : m_n - 1;
        e_addr = {3'(e_slot), bus_if.det_we ? bus_if.det_waddr[3:0] : bus_if.det_raddr[3:0]};
        check("sram_addr_eng", bus_if.sram_addr, e_addr);
      end
    end else begin
      check("host_gnt_idle", bus_if.host_gnt, bus_if.host_req);
      check("sram_addr_host", bus_if.sram_addr, bus_if.host_addr);
      check("sram_we_host", bus_if.sram_we, bus_if.host_we & bus_if.host_req);
      check("sram_wdata_host", bus_if.sram_wdata, bus_if.host_wdata);
    end
  endtask

  int         batch_id = 0;
  logic [7:0] seen_hi [16];
  int         gnt_busy_cnt = 0;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (bus_if.det_go) go_total++;
    if (bus_if.busy) seen_hi[batch_id] = seen_hi[batch_id] | (8'h01 << bus_if.sram_addr[6:4]);
    if (bus_if.busy && bus_if.host_gnt) gnt_busy_cnt++;
    compare_all();
  endtask

  task automatic start_batch(input logic [3:0] jobs);
    go_base = go_total;
    batch_id++;
    bus_if.host_jobs  = jobs;
    bus_if.host_start = 1'b1;
    step();
    bus_if.host_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (bus_if.done) seen = 1'b1;
    end
    check(nm, 32'(seen), 32'd1);
  endtask

  task automatic wait_go(input int target, input int budget, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (go_total - go_base >= target) seen = 1'b1;
    end
    check(nm, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) seen_hi[i] = 8'h00;
    bus_if.host_start = 1'b0; bus_if.host_jobs = 4'd0; bus_if.host_req = 1'b0;
    bus_if.host_we = 1'b0; bus_if.host_addr = '0; bus_if.host_wdata = '0;
    #2 rst_n = 1'b0;
    repeat (3) step();
    check("rst_busy", bus_if.busy, 0);
    check("rst_done", bus_if.done, 0);
    check("rst_det_go", bus_if.det_go, 0);
    check("rst_jobs_done", bus_if.jobs_done, 0);
    check("rst_ovf_mask", bus_if.ovf_mask, 0);
    rst_n = 1'b1;
    step();

    // Host loads words 0..15 while idle.
    bus_if.host_req = 1'b1; bus_if.host_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus_if.host_addr = 7'(i); bus_if.host_wdata = $urandom;
      #1;
      check("load_gnt", bus_if.host_gnt, 1);
      check("load_we", bus_if.sram_we, 1);
      check("load_addr", bus_if.sram_addr, i);
      step();
    end
    bus_if.host_req = 1'b0; bus_if.host_we = 1'b0;
    step();

    // Three jobs of 40 cycles; a start pulse mid-batch must be ignored.
    eng_lat = 40;
    start_batch(4'd3);
    wait_go(1, 5, "b3_first_go");
    bus_if.host_jobs = 4'd5; bus_if.host_start = 1'b1;
    step();
    bus_if.host_start = 1'b0;
    wait_done(300, "b3_done");
    check("b3_go_count", go_total - go_base, 3);
    check("b3_jobs_done", bus_if.jobs_done, 3);
    check("b3_slots_used", seen_hi[batch_id], 8'h07);
    check("b3_ovf_mask", bus_if.ovf_mask, 8'h06);
    step();

    // Six jobs with the engine writing offset 14 and host_req held high throughout.
    eng_lat = 6; eng_fix = 1'b1;
    bus_if.host_req = 1'b1;
    gnt_busy_cnt = 0;
    go_base = go_total;
    batch_id++;
    bus_if.host_jobs = 4'd6; bus_if.host_start = 1'b1;
    #1;
    check("start_cycle_gnt", bus_if.host_gnt, 1);
    step();
    bus_if.host_start = 1'b0;
    wait_go(6, 80, "b6_job5_go");
    step();
    check("job5_waddr14", bus_if.sram_addr, 7'h5E);
    check("job5_we", bus_if.sram_we, 1);
    wait_done(40, "b6_done");
    check("b6_gnt_while_busy", gnt_busy_cnt, 0);
    step();
    check("gnt_after_done", bus_if.host_gnt, 1);
    bus_if.host_req = 1'b0; eng_fix = 1'b0;
    step();

    // Empty batch: done the cycle after start, no engine start.
    start_batch(4'd0);
    check("b0_done", bus_if.done, 1);
    check("b0_no_go", bus_if.det_go, 0);
    step();
    check("b0_idle", bus_if.busy, 0);
    check("b0_go_count", go_total - go_base, 0);

    // Twelve requested -> eight run; finished level held across job boundaries.
    eng_lat = 3; eng_hold = 1'b1;
    start_batch(4'd12);
    wait_done(150, "b12_done");
    check("b12_go_count", go_total - go_base, 8);
    check("b12_jobs_done", bus_if.jobs_done, 8);
    check("b12_ovf_mask", bus_if.ovf_mask, 8'hA6);
    step();
    eng_hold = 1'b0;
    repeat (2) step();

    // Reset in the middle of job 2, then a fresh batch from slot 0.
    eng_lat = 10;
    start_batch(4'd4);
    wait_go(3, 60, "b4_job2_go");
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus_if.busy, 0);
    check("midrst_det_go", bus_if.det_go, 0);
    check("midrst_jobs_done", bus_if.jobs_done, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    eng_lat = 5;
    start_batch(4'd2);
    wait_done(40, "b2_done");
    check("b2_go_count", go_total - go_base, 2);
    check("b2_slots_used", seen_hi[batch_id], 8'h03);
    check("b2_jobs_done", bus_if.jobs_done, 2);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
